memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single external data/instruction memory bus between three requesters:
//  fetch (instruction read), read stage (load) and write stage (store: address/data/address_enable).
//  Sits between the pipeline stages and the Avalon-style memory port. Returns per-requester
//  hold (stall) and done pulses. One transaction outstanding at a time.
// PARAMETERS
//  AW       32  address width (matches regval_t)
//  DW       32  data width (matches regval_t)
//  TIMEOUT  255 max cycles waiting for readdatavalid before abort (8-bit counter)
// PORTS
//  clock             in   1   system clock, all state on rising edge
//  reset_n           in   1   asynchronous active-low reset
//  f_req, f_addr     in   1,AW  fetch read request, address
//  r_req, r_addr     in   1,AW  load read request, address
//  w_req, w_addr     in   1,AW  store request (write stage address_enable), address
//  w_data            in   DW  store data
//  flush             in   1   pipeline flush; discards in-flight fetch result
//  f_hold,r_hold,w_hold out 1 stall to requester: req high and not yet done
//  f_done,r_done,w_done out 1 one-cycle completion pulse
//  rdata             out  DW  read data, valid with f_done/r_done
//  timeout_err       out  1   sticky; set on read timeout, cleared only by reset
//  mem_address       out  AW  bus address
//  mem_writedata     out  DW  bus write data
//  mem_read,mem_write out 1   bus strobes (never both high)
//  mem_waitrequest   in   1   slave not ready; strobes/address held while high
//  mem_readdata      in   DW  bus read data
//  mem_readdatavalid in   1   read data valid
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, mem_* 0, counter 0, rr pointer = fetch.
//  States: IDLE -> ISSUE -> (write: IDLE | read: WAIT_DATA -> IDLE).
//  IDLE: sample requests; grant one; latch owner, address, data; go ISSUE next cycle.
//  ISSUE: drive mem_read/mem_write; hold address, data, strobe stable until mem_waitrequest=0.
//   Write accepted -> w_done pulse same cycle, -> IDLE. Read accepted -> WAIT_DATA, counter=0.
//  WAIT_DATA: mem_readdatavalid -> rdata<=mem_readdata, owner done pulse next cycle, -> IDLE.
//   counter==TIMEOUT -> timeout_err=1, owner done pulse with rdata=0, -> IDLE.
//  hold_x = req_x & ~done_x (combinational). Requester holds req/addr stable until done.
//  Latency, no wait states: write 2 cycles req->done; read 3 cycles + slave latency.
//  Back-to-back: arbiter returns to IDLE for one cycle between transactions.
//  flush: if owner is fetch in ISSUE/WAIT_DATA, transaction completes on bus but f_done is
//   suppressed; flush in IDLE does not block a same-cycle fetch grant.
//  Simultaneous flush and readdatavalid for fetch: data dropped, no f_done.
//  Request dropped mid-transaction (illegal except via flush): bus transaction still completes.
//  Reset mid-transaction: immediate return to IDLE, strobes drop asynchronously.
// CONFIGURATION
//  ARBITER_ROUND_ROBIN_EN defined: round-robin among requesters; pointer moves to the one after
//   the last granted requester. Undefined: fixed priority w > r > f (stores drain first).
// TESTING
//  1 reset_n=0 mid-read -> all strobes/holds/dones 0 immediately; IDLE after release.
//  2 w_req addr=00000010 data=DEADBEEF, waitrequest=0 -> mem_write=1 one cycle, w_done cycle 2.
//  3 r_req addr=00000020, waitrequest 3 cycles, readdatavalid 2 cycles later with 12345678
//    -> address stable 4 cycles, r_done pulse, rdata=12345678, r_hold low the following cycle.
//  4 f_req+r_req+w_req same cycle: fixed -> order w,r,f; round-robin from reset -> order f,r,w.
//  5 fetch read in WAIT_DATA, flush with readdatavalid same cycle -> no f_done, next grant proceeds.
//  6 no readdatavalid for TIMEOUT cycles -> timeout_err=1 sticky, r_done with rdata=00000000.

Source files
------------

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//
// Shares one Avalon-style memory port between three pipeline requesters:
// fetch (instruction read), the read stage (load) and the write stage
// (store). Only one bus transaction is outstanding at a time. Each
// requester gets a combinational hold (stall) and a one-cycle done pulse.
//
// Optional feature macro: ARBITER_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration; the pointer moves to the requester
//                after the one most recently granted (reset pointer: fetch)
//   undefined -> fixed priority, write > read > fetch
//
// Ports
//   clock, reset_n            clock (rising edge), async active-low reset
//   f_req/f_addr              fetch read request and address
//   r_req/r_addr              load read request and address
//   w_req/w_addr/w_data       store request, address and data
//   flush                     discards an in-flight fetch result
//   f_hold/r_hold/w_hold      stall: request pending and not yet done
//   f_done/r_done/w_done      one-cycle completion pulses
//   rdata                     read data, valid with f_done/r_done
//   timeout_err               sticky read-timeout flag, cleared by reset only
//   mem_address/mem_writedata bus address and write data
//   mem_read/mem_write        bus strobes, never both high
//   mem_waitrequest           slave stall; strobes/address held while high
//   mem_readdata/valid        bus read data and its valid strobe
// ---------------------------------------------------------------------------
module memory_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic          r_req,
    input  logic [AW-1:0] r_addr,
    input  logic          w_req,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          flush,
    output logic          f_hold,
    output logic          r_hold,
    output logic          w_hold,
    output logic          f_done,
    output logic          r_done,
    output logic          w_done,
    output logic [DW-1:0] rdata,
    output logic          timeout_err,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_writedata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic          mem_waitrequest,
    input  logic [DW-1:0] mem_readdata,
    input  logic          mem_readdatavalid
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;
    typedef enum logic [1:0] {OWN_F, OWN_R, OWN_W} owner_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    owner_t     owner;
    logic [7:0] wait_cnt;
    logic       fetch_flushed;

    // A requester whose done pulse is showing this cycle is still holding
    // req high for one more edge; it must not be granted a second time.
    logic f_eff, r_eff, w_eff;
    assign f_eff = f_req & ~f_done;
    assign r_eff = r_req & ~r_done;
    assign w_eff = w_req & ~w_done;

    // Stalls are forced low while reset is asserted.
    assign f_hold = reset_n & f_eff;
    assign r_hold = reset_n & r_eff;
    assign w_hold = reset_n & w_eff;

    logic   grant_valid;
    owner_t grant_owner;

`ifdef ARBITER_ROUND_ROBIN_EN
    owner_t rr_ptr;

    // Round-robin: search starts at rr_ptr and wraps f -> r -> w -> f.
    always_comb begin
        grant_valid = f_eff | r_eff | w_eff;
        grant_owner = OWN_F;
        case (rr_ptr)
            OWN_R: begin
                if (r_eff)      grant_owner = OWN_R;
                else if (w_eff) grant_owner = OWN_W;
                else            grant_owner = OWN_F;
            end
            OWN_W: begin
                if (w_eff)      grant_owner = OWN_W;
                else if (f_eff) grant_owner = OWN_F;
                else            grant_owner = OWN_R;
            end
            default: begin
                if (f_eff)      grant_owner = OWN_F;
                else if (r_eff) grant_owner = OWN_R;
                else            grant_owner = OWN_W;
            end
        endcase
    end

    // Pointer advances to the requester after the one just granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= OWN_F;
        end else if (state == IDLE && grant_valid) begin
            case (grant_owner)
                OWN_F:   rr_ptr <= OWN_R;
                OWN_R:   rr_ptr <= OWN_W;
                default: rr_ptr <= OWN_F;
            endcase
        end
    end
`else
    // Fixed priority: stores drain first, then loads, then fetches.
    always_comb begin
        grant_valid = f_eff | r_eff | w_eff;
        grant_owner = OWN_F;
        if (w_eff)      grant_owner = OWN_W;
        else if (r_eff) grant_owner = OWN_R;
        else            grant_owner = OWN_F;
    end
`endif

    // Main transaction FSM with registered bus strobes and done pulses.
    // A fetch that sees flush at any point after its grant completes on the
    // bus but returns neither data nor f_done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            owner         <= OWN_F;
            wait_cnt      <= 8'd0;
            fetch_flushed <= 1'b0;
            f_done        <= 1'b0;
            r_done        <= 1'b0;
            w_done        <= 1'b0;
            rdata         <= '0;
            timeout_err   <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
        end else begin
            f_done <= 1'b0;
            r_done <= 1'b0;
            w_done <= 1'b0;

            if (flush && owner == OWN_F && state != IDLE) begin
                fetch_flushed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner         <= grant_owner;
                        fetch_flushed <= 1'b0;
                        state         <= ISSUE;
                        case (grant_owner)
                            OWN_W: begin
                                mem_address   <= w_addr;
                                mem_writedata <= w_data;
                                mem_write     <= 1'b1;
                            end
                            OWN_R: begin
                                mem_address <= r_addr;
                                mem_read    <= 1'b1;
                            end
                            default: begin
                                mem_address <= f_addr;
                                mem_read    <= 1'b1;
                            end
                        endcase
                    end
                end

                ISSUE: begin
                    if (!mem_waitrequest) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (owner == OWN_W) begin
                            w_done <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            wait_cnt <= 8'd0;
                            state    <= WAIT_DATA;
                        end
                    end
                end

                WAIT_DATA: begin
                    if (mem_readdatavalid) begin
                        state <= IDLE;
                        if (owner == OWN_R) begin
                            rdata  <= mem_readdata;
                            r_done <= 1'b1;
                        end else if (!(flush || fetch_flushed)) begin
                            rdata  <= mem_readdata;
                            f_done <= 1'b1;
                        end
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                        if (owner == OWN_R) begin
                            rdata  <= '0;
                            r_done <= 1'b1;
                        end else if (!(flush || fetch_flushed)) begin
                            rdata  <= '0;
                            f_done <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//
// Scoreboard bench for memory_arbiter. Stimulus pushes the expected
// (requester, read data) for each transaction; a monitor pops and compares
// whenever a done pulse appears. A simple Avalon slave model answers the
// bus with configurable wait states and read latency.
// Define ARBITER_ROUND_ROBIN_EN for both files to check the round-robin build.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int K_F = 0;
    localparam int K_R = 1;
    localparam int K_W = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        f_req, r_req, w_req, flush;
    logic [31:0] f_addr, r_addr, w_addr, w_data;
    logic        f_hold, r_hold, w_hold, f_done, r_done, w_done;
    logic [31:0] rdata;
    logic        timeout_err;
    logic [31:0] mem_address, mem_writedata;
    logic        mem_read, mem_write;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;

    memory_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr),
        .r_req(r_req), .r_addr(r_addr),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
        .flush(flush),
        .f_hold(f_hold), .r_hold(r_hold), .w_hold(w_hold),
        .f_done(f_done), .r_done(r_done), .w_done(w_done),
        .rdata(rdata), .timeout_err(timeout_err),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;

    // Slave configuration, set by the stimulus before each test.
    int          slave_wait = 0;
    int          slave_lat = 0;
    bit          slave_never = 1'b0;
    bit          slave_fixed_en = 1'b0;
    logic [31:0] slave_fixed_data = 32'h0;

    // Bus observation counters, only ever incremented by the monitor.
    int          wr_cycles = 0;
    int          watch_cycles = 0;
    logic [31:0] watch_addr = 32'hFFFF_FFFF;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] last_waddr = 32'h0;

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic done_of(input int kind);
        return (kind == K_F) ? f_done : (kind == K_R) ? r_done : w_done;
    endfunction

    function automatic logic hold_of(input int kind);
        return (kind == K_F) ? f_hold : (kind == K_R) ? r_hold : w_hold;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // Slave model: drives inputs one time unit after each rising edge.
    initial begin
        int          wcnt;
        int          vcnt;
        logic [31:0] acc_addr;
        wcnt = 0;
        vcnt = 0;
        acc_addr = 32'h0;
        mem_waitrequest = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            mem_readdatavalid = 1'b0;
            if (!reset_n) begin
                wcnt = 0;
                vcnt = 0;
                mem_waitrequest = 1'b0;
            end else begin
                if (vcnt > 0) begin
                    vcnt--;
                    if (vcnt == 0) begin
                        mem_readdatavalid = 1'b1;
                        mem_readdata = slave_fixed_en ? slave_fixed_data : slave_rd(acc_addr);
                    end
                end
                if (mem_read || mem_write) begin
                    if (wcnt < slave_wait) begin
                        mem_waitrequest = 1'b1;
                        wcnt++;
                    end else begin
                        mem_waitrequest = 1'b0;
                        wcnt = 0;
                        if (mem_read && !slave_never) begin
                            acc_addr = mem_address;
                            vcnt = slave_lat + 1;
                        end
                    end
                end else begin
                    mem_waitrequest = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse and watches the bus.
    always @(negedge clock) begin
        if (reset_n) begin
            checkOutput("strobe_excl", {31'b0, mem_read & mem_write}, 32'h0);
            if (mem_write) begin
                wr_cycles  <= wr_cycles + 1;
                last_wdata <= mem_writedata;
                last_waddr <= mem_address;
            end
            if (mem_read && mem_address == watch_addr) begin
                watch_cycles <= watch_cycles + 1;
            end
            if (f_done || r_done || w_done) begin
                int   seen;
                exp_t e;
                seen = f_done ? K_F : (r_done ? K_R : K_W);
                checkOutput("done_onehot", 32'(f_done) + 32'(r_done) + 32'(w_done), 32'd1);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_done: got requester %0d, expected none", seen);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("done_owner", seen, e.kind);
                    if (e.kind != K_W) checkOutput("rdata", rdata, e.data);
                end
            end
        end
    end

    // One requester: raise req, wait (bounded) for its done, drop req in the
    // done cycle as a registered pipeline stage would.
    task automatic doRequest(input int kind, input logic [31:0] addr,
                             input logic [31:0] data, output int lat);
        bit got;
        @(posedge clock);
        #1;
        case (kind)
            K_F:     begin f_addr = addr; f_req = 1'b1; end
            K_R:     begin r_addr = addr; r_req = 1'b1; end
            default: begin w_addr = addr; w_data = data; w_req = 1'b1; end
        endcase
        lat = 0;
        got = 1'b0;
        for (int n = 0; n < 600 && !got; n++) begin
            @(negedge clock);
            if (done_of(kind)) begin
                got = 1'b1;
                checkOutput("hold_at_done", {31'b0, hold_of(kind)}, 32'h0);
            end else begin
                if (n == 0) checkOutput("hold_pending", {31'b0, hold_of(kind)}, 32'h1);
                lat++;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL done_wait: requester %0d got no done, expected one within 600 cycles", kind);
        end
        case (kind)
            K_F:     f_req = 1'b0;
            K_R:     r_req = 1'b0;
            default: w_req = 1'b0;
        endcase
    endtask

    task automatic applyStimulus(input int kind, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] exp_data,
                                 output int lat);
        exp_t e;
        e.kind = kind;
        e.data = exp_data;
        sb_q.push_back(e);
        doRequest(kind, addr, data, lat);
    endtask

    task automatic pulseReset();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        int          lf, lr, lw;
        int          base;
        logic [31:0] rd_before;

        reset_n = 1'b0;
        f_req = 0; r_req = 0; w_req = 0; flush = 0;
        f_addr = 0; r_addr = 0; w_addr = 0; w_data = 0;
        repeat (3) @(posedge clock);
        #2;
        checkOutput("rst_mem_read", {31'b0, mem_read}, 32'h0);
        checkOutput("rst_mem_write", {31'b0, mem_write}, 32'h0);
        checkOutput("rst_mem_address", mem_address, 32'h0);
        checkOutput("rst_dones", {29'b0, f_done, r_done, w_done}, 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_timeout_err", {31'b0, timeout_err}, 32'h0);
        reset_n = 1'b1;

        // Reset in the middle of a stalled read.
        slave_wait = 5;
        @(posedge clock);
        #1;
        r_addr = 32'h50;
        r_req = 1'b1;
        @(posedge clock);
        #2;
        checkOutput("midrd_strobe_up", {31'b0, mem_read}, 32'h1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrd_rst_read", {31'b0, mem_read}, 32'h0);
        checkOutput("midrd_rst_hold", {29'b0, f_hold, r_hold, w_hold}, 32'h0);
        checkOutput("midrd_rst_done", {29'b0, f_done, r_done, w_done}, 32'h0);
        r_req = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        checkOutput("post_rst_idle", {30'b0, mem_read, mem_write}, 32'h0);

        // Single write, no wait states.
        slave_wait = 0;
        slave_lat = 0;
        base = wr_cycles;
        applyStimulus(K_W, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, lat);
        checkOutput("wr_latency", lat, 32'd2);
        checkOutput("wr_strobe_cycles", wr_cycles - base, 32'd1);
        checkOutput("wr_data", last_wdata, 32'hDEAD_BEEF);
        checkOutput("wr_addr", last_waddr, 32'h0000_0010);

        // Read with three wait states and two cycles of slave latency.
        slave_wait = 3;
        slave_lat = 2;
        slave_fixed_en = 1'b1;
        slave_fixed_data = 32'h1234_5678;
        watch_addr = 32'h0000_0020;
        base = watch_cycles;
        applyStimulus(K_R, 32'h0000_0020, 32'h0, 32'h1234_5678, lat);
        checkOutput("rd_latency", lat, 32'd8);
        checkOutput("rd_addr_stable", watch_cycles - base, 32'd4);
        @(negedge clock);
        checkOutput("rd_hold_after", {31'b0, r_hold}, 32'h0);

        // Plain fetch, no wait states, no slave latency.
        slave_wait = 0;
        slave_lat = 0;
        slave_fixed_en = 1'b0;
        applyStimulus(K_F, 32'h0000_0080, 32'h0, slave_rd(32'h0000_0080), lat);
        checkOutput("fetch_latency", lat, 32'd3);

        // All three requesters in the same cycle, from a fresh reset.
        pulseReset();
        begin
            exp_t ef, er, ew;
            ef.kind = K_F; ef.data = slave_rd(32'h100);
            er.kind = K_R; er.data = slave_rd(32'h200);
            ew.kind = K_W; ew.data = 32'h0;
`ifdef ARBITER_ROUND_ROBIN_EN
            sb_q.push_back(ef); sb_q.push_back(er); sb_q.push_back(ew);
`else
            sb_q.push_back(ew); sb_q.push_back(er); sb_q.push_back(ef);
`endif
        end
        fork
            doRequest(K_F, 32'h100, 32'h0, lf);
            doRequest(K_R, 32'h200, 32'h0, lr);
            doRequest(K_W, 32'h300, 32'hCAFE_0300, lw);
        join
`ifdef ARBITER_ROUND_ROBIN_EN
        rd_before = slave_rd(32'h200);
        checkOutput("rr_first_lat", lf, 32'd3);
`else
        rd_before = slave_rd(32'h100);
        checkOutput("fixed_first_lat", lw, 32'd2);
`endif

        // Fetch in WAIT_DATA; flush lands with readdatavalid.
        @(posedge clock);
        #1;
        f_addr = 32'h400;
        f_req = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        flush = 1'b1;
        @(negedge clock);
        f_req = 1'b0;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        checkOutput("flush_no_fdone", {31'b0, f_done}, 32'h0);
        checkOutput("flush_rdata_kept", rdata, rd_before);
        applyStimulus(K_R, 32'h0000_0440, 32'h0, slave_rd(32'h440), lat);
        checkOutput("after_flush_lat", lat, 32'd3);
        checkOutput("pre_timeout_err", {31'b0, timeout_err}, 32'h0);

        // Slave never returns data: read times out.
        slave_never = 1'b1;
        applyStimulus(K_R, 32'h0000_0600, 32'h0, 32'h0, lat);
        checkOutput("timeout_latency", lat, 32'd258);
        checkOutput("timeout_err_set", {31'b0, timeout_err}, 32'h1);
        slave_never = 1'b0;
        applyStimulus(K_R, 32'h0000_0700, 32'h0, slave_rd(32'h700), lat);
        checkOutput("timeout_err_sticky", {31'b0, timeout_err}, 32'h1);

        repeat (3) @(posedge clock);
        #2;
        checkOutput("sb_empty", sb_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
